pc_sequencer: RTL

//  Fetch-stage controller. Owns the program counter and drives the instruction ROM address.

---
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage controller. Owns the program counter, drives the synchronous
// instruction ROM address and tags each ROM word with the PC it belongs to.
//
// Next fetch PC is chosen from branch target (EX), jump target (ID), hold, or
// sequential PC+1. Wrong-path fetches are squashed, hazard stalls freeze the
// IF outputs, and a small FSM provides debug halt / single-step.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   stall_i           hazard stall: hold fetch PC and IF outputs
//   jump_i            jump decoded in ID, destination jump_target_i
//   branch_taken_i    branch resolved taken in EX, destination branch_target_i
//   halt_i, step_i    debug halt level and single-step pulse
//   rom_addr_o        ROM address (low Addr_B bits of the fetch PC)
//   pc_o, pc_plus1_o  PC of the word on ROM douta, and that PC + 1
//   if_valid_o        douta is a valid on-path instruction for pc_o
//   flush_o           clear IF/ID this cycle (combinational)
//   state_o           FSM state for debug
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned           width_B  = 32,
    parameter int unsigned           Addr_B   = 10,
    parameter logic [width_B-1:0]    RESET_PC = {width_B{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 jump_i,
    input  logic [width_B-1:0]   jump_target_i,
    input  logic                 branch_taken_i,
    input  logic [width_B-1:0]   branch_target_i,
    input  logic                 halt_i,
    input  logic                 step_i,
    output logic [Addr_B-1:0]    rom_addr_o,
    output logic [width_B-1:0]   pc_o,
    output logic [width_B-1:0]   pc_plus1_o,
    output logic                 if_valid_o,
    output logic                 flush_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } state_t;

    localparam logic [width_B-1:0] PC_ONE = {{(width_B-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nx_s;
    logic [width_B-1:0]   fetch_pc_r;
    logic [width_B-1:0]   fetch_pc_nx_s;
    logic [width_B-1:0]   target_s;
    logic                 redirect_s;
    logic                 fetch_s;
    logic                 valid_nx_s;

    // Next-PC selection, fetch qualification and FSM next state.
    always_comb begin
        redirect_s    = branch_taken_i | jump_i;
        target_s      = jump_target_i;
        fetch_s       = 1'b0;
        fetch_pc_nx_s = fetch_pc_r;
        state_nx_s    = state_r;

        // EX branch is older than the ID jump, so it wins.
        if (branch_taken_i) begin
            target_s = branch_target_i;
        end else begin
            target_s = jump_target_i;
        end

        // A fetch only advances in RUN (not halting) or STEP, and never under stall.
        case (state_r)
            RUN:     fetch_s = ~halt_i & ~stall_i;
            STEP:    fetch_s = ~stall_i;
            default: fetch_s = 1'b0;
        endcase

        // The ROM was addressed with RESET_PC during reset, so the BOOT edge
        // moves straight on to the next word; that primed word is not tagged valid.
        if (state_r == BOOT) begin
            fetch_pc_nx_s = fetch_pc_r + PC_ONE;
        end else if (redirect_s) begin
            fetch_pc_nx_s = target_s;
        end else if (fetch_s) begin
            fetch_pc_nx_s = fetch_pc_r + PC_ONE;
        end else begin
            fetch_pc_nx_s = fetch_pc_r;
        end

        // Whatever is fetched in a redirect cycle is on the wrong path.
        valid_nx_s = fetch_s & ~redirect_s;

        case (state_r)
            BOOT:    state_nx_s = RUN;
            RUN:     state_nx_s = halt_i ? HALT : RUN;
            HALT: begin
                if (step_i) begin
                    state_nx_s = STEP;
                end else if (!halt_i) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = HALT;
                end
            end
            STEP:    state_nx_s = stall_i ? STEP : HALT;
            default: state_nx_s = BOOT;
        endcase
    end

    // FSM, fetch PC and registered IF outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= BOOT;
            fetch_pc_r <= RESET_PC;
            pc_o       <= RESET_PC;
            pc_plus1_o <= RESET_PC + PC_ONE;
            if_valid_o <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            fetch_pc_r <= fetch_pc_nx_s;
            // A stall freezes the IF outputs, except that a redirect must still
            // drop if_valid_o so the stale word is not re-presented as on-path.
            if (redirect_s || !stall_i) begin
                pc_o       <= fetch_pc_r;
                pc_plus1_o <= fetch_pc_r + PC_ONE;
                if_valid_o <= valid_nx_s;
            end
        end
    end

    assign rom_addr_o = fetch_pc_r[Addr_B-1:0];
    assign flush_o    = branch_taken_i | (jump_i & ~branch_taken_i);
    assign state_o    = state_r;

endmodule
